bird_ctrl: RTL and testbench

Per-frame bird motion controller: integrates gravity and flap impulses in fixed point, derives the nose angle and wing-animation frame, and tracks the bird life cycle (idle hover, flying, falling after a crash, grounded). It sits directly upstream of the rotated-sprite renderer and drives its `pos_x`, `pos_y`, `angle` and `bird_status` inputs. All state advances only on `frame_tick`.

---
 rtl/bird_pkg.sv | 32 +++
 rtl/bird_anim.sv | 56 +++++
 rtl/bird_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_bird_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bird_pkg.sv
// Shared types and constants for the bird motion controller and its sprite renderer.
package bird_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLY,
        ST_FALL,
        ST_GROUND
    } bird_state_e;

    localparam int FRAC_BITS = 4;
    localparam int ANGLE_MAX = 63;

    localparam logic [1:0] FRAME_0 = 2'd0;
    localparam logic [1:0] FRAME_1 = 2'd1;
    localparam logic [1:0] FRAME_2 = 2'd2;

    // Wing sequence 0,1,2,1 indexed by a 2-bit step.
    function automatic logic [1:0] frame_of_step(input logic [1:0] step);
        case (step)
            2'd0:    return FRAME_0;
            2'd2:    return FRAME_2;
            default: return FRAME_1;
        endcase
    endfunction

    // Triangle wave of the 5-bit bob counter, divided by 4; takes bits [4:2] only.
    function automatic logic [1:0] bob_offset(input logic [2:0] c_hi);
        return c_hi[2] ? ~c_hi[1:0] : c_hi[1:0];
    endfunction

endpackage

// File: rtl/bird_anim.sv
// Wing-animation sequencer: divides frame ticks by ANIM_DIV and walks 0,1,2,1; freeze pins frame 1.
module bird_anim
    import bird_pkg::*;
#(
    parameter int ANIM_DIV = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick,
    input  logic       freeze,
    input  logic       clear,
    output logic [1:0] status
);

    localparam logic [7:0] DIV_LAST = 8'(ANIM_DIV - 1);

    logic [7:0] div_reg, div_next;
    logic [1:0] step_reg, step_next;
    logic [1:0] status_reg, status_next;

    always_comb begin
        div_next    = div_reg;
        step_next   = step_reg;
        status_next = status_reg;
        if (tick) begin
            if (clear) begin
                div_next    = '0;
                step_next   = '0;
                status_next = FRAME_0;
            end else if (freeze) begin
                status_next = FRAME_1;
            end else if (div_reg == DIV_LAST) begin
                div_next    = '0;
                step_next   = step_reg + 2'd1;
                status_next = frame_of_step(step_next);
            end else begin
                div_next = div_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_reg    <= '0;
            step_reg   <= '0;
            status_reg <= FRAME_0;
        end else begin
            div_reg    <= div_next;
            step_reg   <= step_next;
            status_reg <= status_next;
        end
    end

    assign status = status_reg;

endmodule

// File: rtl/bird_ctrl.sv
// Per-frame bird physics and life-cycle FSM; feeds position, angle and sprite frame to the renderer.
module bird_ctrl
    import bird_pkg::*;
#(
    parameter int START_X     = 60,
    parameter int START_Y     = 200,
    parameter int GROUND_Y    = 400,
    parameter int GRAVITY     = 6,
    parameter int FLAP_V      = 90,
    parameter int MAX_VY      = 160,
    parameter int ANGLE_UP    = -16,
    parameter int ANGLE_STEP  = 3,
    parameter int HOLD_FRAMES = 8,
    parameter int ANIM_DIV    = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               frame_tick,
    input  logic               flap,
    input  logic               start,
    input  logic               crash,
    output logic signed [15:0] pos_x,
    output logic signed [15:0] pos_y,
    output logic signed [7:0]  angle,
    output logic [1:0]         bird_status,
    output logic               alive,
    output logic               grounded
);

    localparam logic signed [19:0] START_Y_FP  = 20'(START_Y << FRAC_BITS);
    localparam logic signed [20:0] GROUND_FP   = 21'(GROUND_Y << FRAC_BITS);
    localparam logic signed [12:0] GRAV_C      = 13'(GRAVITY);
    localparam logic signed [12:0] MAX_VY_C    = 13'(MAX_VY);
    localparam logic signed [11:0] FLAP_VY     = 12'(-FLAP_V);
    localparam logic signed [8:0]  ANG_STEP_C  = 9'(ANGLE_STEP);
    localparam logic signed [8:0]  ANG_MAX_W   = 9'(ANGLE_MAX);
    localparam logic signed [7:0]  ANG_TOP     = 8'(ANGLE_MAX);
    localparam logic signed [7:0]  ANG_UP_C    = 8'(ANGLE_UP);
    localparam logic [7:0]         HOLD_C      = 8'(HOLD_FRAMES);

    bird_state_e        state_reg, state_next;
    logic signed [19:0] y_fp_reg, y_fp_next;
    logic signed [11:0] vy_reg, vy_next;
    logic signed [7:0]  angle_reg, angle_next;
    logic [7:0]         hold_reg, hold_next;
    logic [4:0]         bob_reg, bob_next;
    logic               pend_flap_reg, pend_start_reg, pend_crash_reg;

    logic               flap_e, start_e, crash_e;
    logic signed [12:0] vy_sum;
    logic signed [11:0] vy_grav, vy_n;
    logic signed [20:0] y_sum;
    logic signed [8:0]  ang_sum;
    logic signed [7:0]  ang_inc;
    logic               motion, flap_now, anim_clear, anim_freeze;

    // A pulse coinciding with the tick is honoured on that same tick.
    assign flap_e  = pend_flap_reg  | flap;
    assign start_e = pend_start_reg | start;
    assign crash_e = pend_crash_reg | crash;

    always_ff @(posedge clk) begin
        if (!rstn || frame_tick) begin
            pend_flap_reg  <= 1'b0;
            pend_start_reg <= 1'b0;
            pend_crash_reg <= 1'b0;
        end else begin
            pend_flap_reg  <= pend_flap_reg  | flap;
            pend_start_reg <= pend_start_reg | start;
            pend_crash_reg <= pend_crash_reg | crash;
        end
    end

    always_comb begin
        state_next = state_reg;
        y_fp_next  = y_fp_reg;
        vy_next    = vy_reg;
        angle_next = angle_reg;
        hold_next  = hold_reg;
        bob_next   = bob_reg;
        motion     = 1'b0;
        flap_now   = 1'b0;
        anim_clear = 1'b0;

        vy_sum  = $signed({vy_reg[11], vy_reg}) + GRAV_C;
        vy_grav = (vy_sum > MAX_VY_C) ? MAX_VY_C[11:0] : vy_sum[11:0];
        ang_sum = $signed({angle_reg[7], angle_reg}) + ANG_STEP_C;
        ang_inc = (ang_sum > ANG_MAX_W) ? ANG_TOP : ang_sum[7:0];

        if (frame_tick) begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_e) begin
                        state_next = ST_FLY;
                        motion     = 1'b1;
                        flap_now   = 1'b1;
                    end else begin
                        bob_next  = bob_reg + 5'd1;
                        y_fp_next = START_Y_FP + {14'd0, bob_offset(bob_next[4:2]), 4'd0};
                    end
                end
                ST_FLY: begin
                    // Crash outranks flap; upward motion is killed, downward kept.
                    if (crash_e) begin
                        state_next = ST_FALL;
                        if (vy_reg < 0) vy_next = '0;
                    end else begin
                        motion   = 1'b1;
                        flap_now = flap_e;
                    end
                end
                ST_FALL: motion = 1'b1;
                ST_GROUND: begin
                    if (start_e) begin
                        state_next = ST_IDLE;
                        y_fp_next  = START_Y_FP;
                        vy_next    = '0;
                        angle_next = '0;
                        hold_next  = '0;
                        bob_next   = '0;
                        anim_clear = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        vy_n  = flap_now ? FLAP_VY : vy_grav;
        y_sum = $signed({y_fp_reg[19], y_fp_reg}) + $signed({{9{vy_n[11]}}, vy_n});

        if (motion) begin
            vy_next = vy_n;
            if (state_reg == ST_FALL) begin
                angle_next = ang_inc;
            end else if (flap_now) begin
                angle_next = ANG_UP_C;
                hold_next  = HOLD_C;
            end else if (hold_reg != 8'd0) begin
                hold_next = hold_reg - 8'd1;
            end else begin
                angle_next = ang_inc;
            end

            if (y_sum < 0) begin
                y_fp_next = '0;
                vy_next   = '0;
            end else if (y_sum >= GROUND_FP) begin
                y_fp_next  = GROUND_FP[19:0];
                vy_next    = '0;
                angle_next = ANG_TOP;
                state_next = ST_GROUND;
            end else begin
                y_fp_next = y_sum[19:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            y_fp_reg  <= START_Y_FP;
            vy_reg    <= '0;
            angle_reg <= '0;
            hold_reg  <= '0;
            bob_reg   <= '0;
        end else begin
            state_reg <= state_next;
            y_fp_reg  <= y_fp_next;
            vy_reg    <= vy_next;
            angle_reg <= angle_next;
            hold_reg  <= hold_next;
            bob_reg   <= bob_next;
        end
    end

    // Freeze follows the state being entered so the sprite changes on the same tick.
    assign anim_freeze = (state_next == ST_FALL) || (state_next == ST_GROUND);

    bird_anim #(
        .ANIM_DIV(ANIM_DIV)
    ) u_anim (
        .clk   (clk),
        .rstn  (rstn),
        .tick  (frame_tick),
        .freeze(anim_freeze),
        .clear (anim_clear),
        .status(bird_status)
    );

    assign pos_x    = 16'(START_X);
    assign pos_y    = y_fp_reg[19:4];
    assign angle    = angle_reg;
    assign alive    = (state_reg == ST_IDLE) || (state_reg == ST_FLY);
    assign grounded = (state_reg == ST_GROUND);

endmodule

// File: tb/tb_bird_ctrl.sv
// Bench for bird_ctrl: vector table plus hand sequences, expectations queued per frame.
module tb_bird_ctrl;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic frame_tick = 1'b0;
    logic flap = 1'b0;
    logic start = 1'b0;
    logic crash = 1'b0;
    logic signed [15:0] pos_x, pos_y;
    logic signed [7:0]  angle;
    logic [1:0]         bird_status;
    logic               alive, grounded;

    always #5 clk = ~clk;

    bird_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .frame_tick (frame_tick),
        .flap       (flap),
        .start      (start),
        .crash      (crash),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .angle      (angle),
        .bird_status(bird_status),
        .alive      (alive),
        .grounded   (grounded)
    );

    localparam logic [4:0] M_PY = 5'd1, M_ANG = 5'd2, M_ST = 5'd4, M_ALV = 5'd8, M_GND = 5'd16;
    localparam logic [4:0] M_ALL = 5'd31;

    typedef struct {
        int         py;
        int         ang;
        int         st;
        int         alv;
        int         gnd;
        logic [4:0] mask;
    } exp_t;

    typedef struct {
        bit   pre_rst;
        bit   f;
        bit   s;
        bit   c;
        bit   same;
        exp_t e;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[9];
    int   n_chk = 0;
    int   n_pass = 0;
    int   frame_no = 0;

    int   my, mvy, mhold, mang, yn, prev_py, a1, a2;
    bit   mgnd;

    function automatic exp_t mk(input int py, ang, st, alv, gnd, input logic [4:0] m);
        exp_t e;
        e.py = py; e.ang = ang; e.st = st; e.alv = alv; e.gnd = gnd; e.mask = m;
        return e;
    endfunction

    function automatic vec_t mkv(input bit pr, f, s, c, same, input exp_t e);
        vec_t v;
        v.pre_rst = pr; v.f = f; v.s = s; v.c = c; v.same = same; v.e = e;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic check_out();
        exp_t e;
        frame_no++;
        $display("frame %0d: pos_y=%0d angle=%0d status=%0d alive=%0d grounded=%0d",
                 frame_no, pos_y, angle, bird_status, alive, grounded);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            if (e.mask[0]) chk("pos_y", int'(pos_y), e.py);
            if (e.mask[1]) chk("angle", int'(angle), e.ang);
            if (e.mask[2]) chk("bird_status", int'(bird_status), e.st);
            if (e.mask[3]) chk("alive", int'(alive), e.alv);
            if (e.mask[4]) chk("grounded", int'(grounded), e.gnd);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        $display("%s: pos_x=%0d pos_y=%0d angle=%0d status=%0d alive=%0d grounded=%0d",
                 tag, pos_x, pos_y, angle, bird_status, alive, grounded);
        chk({tag, "_pos_x"}, int'(pos_x), 60);
        chk({tag, "_pos_y"}, int'(pos_y), 200);
        chk({tag, "_angle"}, int'(angle), 0);
        chk({tag, "_status"}, int'(bird_status), 0);
        chk({tag, "_alive"}, int'(alive), 1);
        chk({tag, "_grounded"}, int'(grounded), 0);
    endtask

    // Pulses either one cycle ahead of the tick (latched) or on the tick cycle itself.
    task automatic do_frame(input bit f, s, c, same, input exp_t e);
        @(negedge clk);
        if (!same && (f || s || c)) begin
            flap = f; start = s; crash = c;
            @(negedge clk);
            flap = 1'b0; start = 1'b0; crash = 1'b0;
        end
        if (same) begin
            flap = f; start = s; crash = c;
        end
        frame_tick = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        frame_tick = 1'b0; flap = 1'b0; start = 1'b0; crash = 1'b0;
        check_out();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = mkv(0, 0, 0, 0, 0, mk(200, 0, 0, 1, 0, M_ALL));
        vecs[1] = mkv(0, 0, 0, 0, 0, mk(200, 0, 0, 1, 0, M_ALL));
        vecs[2] = mkv(0, 0, 0, 0, 0, mk(200, 0, 0, 1, 0, M_ALL));
        vecs[3] = mkv(0, 0, 0, 0, 0, mk(201, 0, 1, 1, 0, M_ALL));
        vecs[4] = mkv(1, 0, 1, 0, 1, mk(194, -16, 0, 1, 0, M_ALL));
        vecs[5] = mkv(0, 0, 0, 0, 0, mk(189, -16, 0, 1, 0, M_ALL));
        vecs[6] = mkv(0, 0, 0, 0, 0, mk(184, -16, 0, 1, 0, M_ALL));
        vecs[7] = mkv(0, 0, 0, 0, 0, mk(179, -16, 1, 1, 0, M_ALL));
        vecs[8] = mkv(0, 1, 0, 0, 0, mk(174, -16, 1, 1, 0, M_ALL));

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        check_reset("reset");

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].pre_rst) do_reset();
            do_frame(vecs[i].f, vecs[i].s, vecs[i].c, vecs[i].same, vecs[i].e);
        end

        // Angle hold/clamp and long fall to the ground after the last flap.
        my = 2786; mvy = -90; mhold = 8; mang = -16; mgnd = 1'b0; prev_py = 174;
        for (int k = 0; k < 120 && !mgnd; k++) begin
            mvy = (mvy + 6 > 160) ? 160 : mvy + 6;
            yn  = my + mvy;
            if (yn >= 6400) begin
                my = 6400; mvy = 0; mang = 63; mgnd = 1'b1;
            end else begin
                my = yn;
                if (mhold > 0) mhold--;
                else mang = (mang + 3 > 63) ? 63 : mang + 3;
            end
            do_frame(0, 0, 0, 0, mk(my >>> 4, mang, 1, mgnd ? 0 : 1, mgnd ? 1 : 0,
                                    mgnd ? M_ALL : (M_PY | M_ANG | M_ALV | M_GND)));
            if (!mgnd && mvy == 160) chk("fall_step_10px", int'(pos_y) - prev_py, 10);
            prev_py = int'(pos_y);
        end
        if (!mgnd) chk("ground_reached", 0, 1);

        // Grounded: frozen despite a flap, then start reinitialises to IDLE.
        do_frame(1, 0, 0, 0, mk(400, 63, 1, 0, 1, M_ALL));
        do_frame(0, 1, 0, 0, mk(200, 0, 0, 1, 0, M_ALL));
        do_frame(0, 0, 0, 0, mk(200, 0, 0, 1, 0, M_ALL));

        // Crash and flap in one frame: crash wins, later flaps ignored.
        do_frame(0, 1, 0, 0, mk(194, -16, 0, 1, 0, M_ALL));
        do_frame(1, 0, 1, 0, mk(0, 0, 1, 0, 0, M_ST | M_ALV | M_GND));
        do_frame(1, 0, 0, 0, mk(194, 0, 1, 0, 0, M_PY | M_ST | M_ALV | M_GND));
        a1 = int'(angle);
        do_frame(1, 0, 0, 0, mk(195, 0, 1, 0, 0, M_PY | M_ST | M_ALV | M_GND));
        a2 = int'(angle);
        chk("fall_angle_step", a2 - a1, 3);

        // Reset mid-fall with a start pending: everything returns to reset values.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rstn  = 1'b0;
        @(negedge clk);
        rstn  = 1'b1;
        check_reset("midfall_reset");
        do_frame(0, 0, 0, 0, mk(200, 0, 0, 1, 0, M_ALL));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
